// File: rtl/hsynth_audio_pkg.sv
// Shared definitions for the synth audio path: default sample width,
// the capture word layout seen by the APB capture/DMA block, and the
// states of the capture write-pulse FSM.
package hsynth_audio_pkg;

    localparam int SAMPLE_W_DEF = 32;

    // Capture word layout at the default sample width: left in the upper half.
    localparam int CAP_W = 2 * SAMPLE_W_DEF;
    localparam int L_MSB = CAP_W - 1;
    localparam int L_LSB = SAMPLE_W_DEF;
    localparam int R_MSB = SAMPLE_W_DEF - 1;
    localparam int R_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/hsynth_i2s_timing.sv
// I2S master timing: divides clk down to bclk, tracks the bit position
// within the stereo frame and drives lrclk with the standard one-bit
// delay. Emits a strobe for every bclk high->low toggle and a frame-load
// strobe on the toggle that wraps the bit counter back to 0.
module hsynth_i2s_timing
    import hsynth_audio_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic lrclk,
    output logic bclk_fall,
    output logic frame_load
);

    localparam int FRAME_BITS = 2 * SAMPLE_W;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_next;
    logic             div_tc;
    logic             lr_next;

    assign div_tc       = (div_cnt == DIV_LAST);
    assign bclk_fall    = div_tc & bclk;
    assign frame_load   = bclk_fall & (bit_cnt == BIT_LAST);
    assign bit_cnt_next = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

    // lrclk goes high one bit early so the right MSB lands one bclk after the switch
    assign lr_next = (int'(bit_cnt_next) >= SAMPLE_W - 1) &&
                     (int'(bit_cnt_next) <= FRAME_BITS - 2);

    // Divider, bit clock, bit position and word select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            lrclk   <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (bclk_fall) begin
                bit_cnt <= bit_cnt_next;
                lrclk   <= lr_next;
            end
        end
    end

endmodule

// File: rtl/hsynth_capture_serializer.sv
// Takes stereo pairs from the synth mixer, plays them out as an I2S master
// and mirrors every transmitted frame into the capture path as one word
// qualified by a wide write pulse. The consumer resynchronises the pulse
// and writes on its falling edge, so the word is frozen through a hold
// window after the pulse drops.
module hsynth_capture_serializer
    import hsynth_audio_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int WR_PULSE = 4,
    parameter int WR_HOLD  = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SAMPLE_W-1:0]   sample_l,
    input  logic [SAMPLE_W-1:0]   sample_r,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic                  i2s_capture_enable,
    input  logic                  capture_fifo_full,
    output logic [2*SAMPLE_W-1:0] capture_fifo_data,
    output logic                  i2s_capture_fifo_write,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic [CNT_W-1:0]      underrun_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int PH_MAX  = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
    localparam int PH_W    = $clog2(PH_MAX);

    localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(WR_PULSE - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(WR_HOLD - 1);

    logic               bclk_fall;
    logic               frame_load;
    logic               hold_valid;
    logic [FRAME_W-1:0] hold_pair;
    logic [FRAME_W-1:0] shreg;
    logic               capture_req;
    wr_state_t          state;
    logic [PH_W-1:0]    phase_cnt;

    hsynth_i2s_timing #(
        .BCLK_DIV (BCLK_DIV),
        .SAMPLE_W (SAMPLE_W)
    ) u_timing (
        .clk        (clk),
        .reset_n    (reset_n),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .bclk_fall  (bclk_fall),
        .frame_load (frame_load)
    );

    assign sample_ready = ~hold_valid;
    assign sdata        = shreg[FRAME_W-1];
    assign capture_req  = frame_load & hold_valid & i2s_capture_enable & ~capture_fifo_full;

    // Holding register: a new handshake wins over the frame load emptying it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_pair  <= '0;
        end else begin
            if (frame_load) begin
                hold_valid <= 1'b0;
            end
            if (sample_valid && sample_ready) begin
                hold_valid <= 1'b1;
                hold_pair  <= {sample_l, sample_r};
            end
        end
    end

    // Output shift register and underrun accounting; empty frames send silence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg        <= '0;
            underrun_cnt <= '0;
        end else if (frame_load) begin
            if (hold_valid) begin
                shreg <= hold_pair;
            end else begin
                shreg <= '0;
                if (underrun_cnt != '1) begin
                    underrun_cnt <= underrun_cnt + 1'b1;
                end
            end
        end else if (bclk_fall) begin
            shreg <= shreg << 1;
        end
    end

    // Capture write FSM: latch the word, pulse write, then hold the word stable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            phase_cnt              <= '0;
            i2s_capture_fifo_write <= 1'b0;
            capture_fifo_data      <= '0;
            drop_cnt               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture_req) begin
                        state                  <= PULSE;
                        phase_cnt              <= '0;
                        i2s_capture_fifo_write <= 1'b1;
                        capture_fifo_data      <= hold_pair;
                    end
                end
                PULSE: begin
                    if (phase_cnt == PULSE_LAST) begin
                        state                  <= HOLD;
                        phase_cnt              <= '0;
                        i2s_capture_fifo_write <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state                  <= IDLE;
                    phase_cnt              <= '0;
                    i2s_capture_fifo_write <= 1'b0;
                end
            endcase
            if (capture_req && (state != IDLE) && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hsynth_capture_serializer.sv
// Directed bench for hsynth_capture_serializer. Instance A uses BCLK_DIV=2
// with the default 32-bit slots; instance B is the deliberately undersized
// configuration whose write window outlasts a frame.
module tb_hsynth_capture_serializer;

    logic clk;
    logic reset_n;

    // Instance A signals
    logic [31:0] a_l, a_r;
    logic        a_valid, a_ready, a_en, a_full;
    logic [63:0] a_data;
    logic        a_write, a_bclk, a_lrclk, a_sdata;
    logic [15:0] a_underrun, a_drop;

    // Instance B signals
    logic [0:0]  b_l, b_r;
    logic        b_valid, b_ready, b_en, b_full;
    logic [1:0]  b_data;
    logic        b_write, b_bclk, b_lrclk, b_sdata;
    logic [15:0] b_underrun, b_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] stim [0:4];

    // Monitor records for instance A
    int          rise_cyc [$];
    logic [63:0] rise_data [$];
    int          widths [$];
    int          hi_len = 0;
    int          bad_change = 0;
    logic        prev_write = 1'b0;
    logic [63:0] prev_data = '0;

    hsynth_capture_serializer #(
        .BCLK_DIV (2), .SAMPLE_W (32), .WR_PULSE (4), .WR_HOLD (4), .CNT_W (16)
    ) dut_a (
        .clk                    (clk),
        .reset_n                (reset_n),
        .sample_l               (a_l),
        .sample_r               (a_r),
        .sample_valid           (a_valid),
        .sample_ready           (a_ready),
        .i2s_capture_enable     (a_en),
        .capture_fifo_full      (a_full),
        .capture_fifo_data      (a_data),
        .i2s_capture_fifo_write (a_write),
        .bclk                   (a_bclk),
        .lrclk                  (a_lrclk),
        .sdata                  (a_sdata),
        .underrun_cnt           (a_underrun),
        .drop_cnt               (a_drop)
    );

    hsynth_capture_serializer #(
        .BCLK_DIV (2), .SAMPLE_W (1), .WR_PULSE (8), .WR_HOLD (4), .CNT_W (16)
    ) dut_b (
        .clk                    (clk),
        .reset_n                (reset_n),
        .sample_l               (b_l),
        .sample_r               (b_r),
        .sample_valid           (b_valid),
        .sample_ready           (b_ready),
        .i2s_capture_enable     (b_en),
        .capture_fifo_full      (b_full),
        .capture_fifo_data      (b_data),
        .i2s_capture_fifo_write (b_write),
        .bclk                   (b_bclk),
        .lrclk                  (b_lrclk),
        .sdata                  (b_sdata),
        .underrun_cnt           (b_underrun),
        .drop_cnt               (b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Watches instance A's write pulses and checks the word never moves outside a rise
    always @(posedge clk) begin
        #2;
        if (reset_n) begin
            if (a_write && !prev_write) begin
                rise_cyc.push_back(cyc);
                rise_data.push_back(a_data);
            end
            if (a_write) hi_len++;
            if (!a_write && prev_write) begin
                widths.push_back(hi_len);
                hi_len = 0;
            end
            if ((a_data != prev_data) && !(a_write && !prev_write)) bad_change++;
        end
        prev_write = a_write;
        prev_data  = a_data;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic releaseReset();
        reset_n = 1'b1;
        cyc = 0;
        rise_cyc.delete();
        rise_data.delete();
        widths.delete();
        hi_len = 0;
        bad_change = 0;
    endtask

    task automatic applyReset();
        a_valid = 1'b0; a_l = '0; a_r = '0; a_en = 1'b1; a_full = 1'b0;
        b_valid = 1'b0; b_l = '0; b_r = '0; b_en = 1'b1; b_full = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        releaseReset();
    endtask

    // Feeds stim[0..n_pairs-1] whenever ready, holding capture_fifo_full over [full_lo, full_hi)
    task automatic applyStimulus(input int n_pairs, input int n_cycles,
                                 input int full_lo, input int full_hi);
        int  idx;
        logic hs;
        idx = 0;
        for (int i = 0; i < n_cycles; i++) begin
            a_full  = (cyc >= full_lo) && (cyc < full_hi);
            a_valid = (idx < n_pairs);
            {a_l, a_r} = (idx < n_pairs) ? stim[idx] : 64'h0;
            hs = a_valid && a_ready;
            tick();
            if (hs) idx++;
        end
        a_valid = 1'b0;
        a_full  = 1'b0;
    endtask

    task automatic waitWrite(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            if (a_write) found = 1'b1;
        end
    endtask

    initial begin
        bit          found;
        logic [63:0] pair;
        logic [63:0] obs_sd, obs_lr, exp_lr, obs_bh;
        int          idx, rises, high;
        logic        hs, prevw;

        stim[0] = 64'h1111_0001_2222_0001;
        stim[1] = 64'h3333_0002_4444_0002;
        stim[2] = 64'h5555_0003_6666_0003;
        stim[3] = 64'h7777_0004_8888_0004;
        stim[4] = 64'h9999_0005_AAAA_0005;

        // ---- 1: single pair, bit stream, capture word and pulse shape
        applyReset();
        checkOutput("reset_ready",    {63'h0, a_ready}, 64'h1);
        checkOutput("reset_outs",     {59'h0, a_bclk, a_lrclk, a_sdata, a_write, 1'b0}, 64'h0);
        checkOutput("reset_data",     a_data, 64'h0);
        checkOutput("reset_counters", {32'h0, a_underrun, a_drop}, 64'h0);
        pair = 64'hA5A5_0001_8000_0000;
        {a_l, a_r} = pair;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checkOutput("t1_ready_drop", {63'h0, a_ready}, 64'h0);
        waitWrite(400, found);
        checkOutput("t1_write_seen", {63'h0, found}, 64'h1);
        checkOutput("t1_load_cycle", 64'(cyc), 64'd256);
        checkOutput("t1_capture_data", a_data, pair);
        checkOutput("t1_ready_back", {63'h0, a_ready}, 64'h1);
        checkOutput("t1_at_load_bclk_lr_sd", {61'h0, a_bclk, a_lrclk, a_sdata}, 64'b001);
        tick();
        tick();
        for (int k = 0; k < 64; k++) begin
            obs_sd[63-k] = a_sdata;
            obs_lr[63-k] = a_lrclk;
            obs_bh[63-k] = a_bclk;
            exp_lr[63-k] = (k >= 31) && (k <= 62);
            if (k < 63) begin
                tick(); tick(); tick(); tick();
            end
        end
        checkOutput("t1_sdata_stream", obs_sd, pair);
        checkOutput("t1_lrclk_stream", obs_lr, exp_lr);
        checkOutput("t1_bclk_high_at_sample", obs_bh, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t1_pulse_count", 64'(widths.size()), 64'd1);
        for (int i = 0; i < widths.size(); i++)
            checkOutput("t1_pulse_width", 64'(widths[i]), 64'd4);
        checkOutput("t1_data_stable", 64'(bad_change), 64'd0);
        checkOutput("t1_data_after_hold", a_data, pair);

        // ---- 2: no samples for three frames
        applyReset();
        obs_sd = '0;
        obs_bh = 64'h1;
        for (int i = 0; i < 800; i++) begin
            tick();
            obs_sd[0] = obs_sd[0] | a_sdata;
            obs_bh[0] = obs_bh[0] & a_ready;
        end
        checkOutput("t2_sdata_silent", obs_sd, 64'h0);
        checkOutput("t2_ready_stays", obs_bh, 64'h1);
        checkOutput("t2_underrun", {48'h0, a_underrun}, 64'd3);
        checkOutput("t2_no_pulses", 64'(rise_cyc.size()), 64'd0);

        // ---- 3: back-to-back pairs for five frames
        applyReset();
        applyStimulus(5, 1300, 0, 0);
        checkOutput("t3_pulse_count", 64'(rise_cyc.size()), 64'd5);
        for (int i = 0; i < rise_cyc.size(); i++) begin
            checkOutput("t3_rise_cycle", 64'(rise_cyc[i]), 64'(256 * (i + 1)));
            checkOutput("t3_rise_data", rise_data[i], stim[i]);
        end
        checkOutput("t3_drop", {48'h0, a_drop}, 64'd0);
        checkOutput("t3_underrun", {48'h0, a_underrun}, 64'd0);
        checkOutput("t3_data_stable", 64'(bad_change), 64'd0);

        // ---- 4: capture FIFO full around the second frame load
        applyReset();
        applyStimulus(3, 800, 400, 600);
        checkOutput("t4_pulse_count", 64'(rise_cyc.size()), 64'd2);
        if (rise_data.size() == 2) begin
            checkOutput("t4_first_word", rise_data[0], stim[0]);
            checkOutput("t4_second_word", rise_data[1], stim[2]);
        end
        checkOutput("t4_drop", {48'h0, a_drop}, 64'd0);
        checkOutput("t4_underrun", {48'h0, a_underrun}, 64'd0);

        // ---- 5: undersized config drops the second capture
        applyReset();
        idx = 0; rises = 0; high = 0; prevw = 1'b0;
        for (int i = 0; i < 36; i++) begin
            b_valid = (idx < 2);
            {b_l, b_r} = (idx == 0) ? 2'b10 : 2'b01;
            hs = b_valid && b_ready;
            tick();
            if (hs) idx++;
            if (b_write && !prevw) rises++;
            if (b_write) high++;
            prevw = b_write;
        end
        b_valid = 1'b0;
        checkOutput("t5_drop", {48'h0, b_drop}, 64'd1);
        checkOutput("t5_pulses", 64'(rises), 64'd1);
        checkOutput("t5_pulse_len", 64'(high), 64'd8);
        checkOutput("t5_data", {62'h0, b_data}, 64'b10);
        checkOutput("t5_underrun", {48'h0, b_underrun}, 64'd2);

        // ---- 6: reset in the middle of the right slot
        applyReset();
        stim[0] = 64'hC3C3_1234_00FF_8001;
        applyStimulus(1, 416, 0, 0);
        checkOutput("t6_pre_lr_sd", {62'h0, a_lrclk, a_sdata}, 64'b11);
        checkOutput("t6_pre_data", a_data, stim[0]);
        reset_n = 1'b0;
        #2;
        checkOutput("t6_rst_outs", {59'h0, a_bclk, a_lrclk, a_sdata, a_write, a_ready}, 64'b00001);
        checkOutput("t6_rst_data", a_data, 64'h0);
        checkOutput("t6_rst_counters", {32'h0, a_underrun, a_drop}, 64'h0);
        tick();
        tick();
        releaseReset();
        checkOutput("t6_bit_cnt_zero", 64'(dut_a.u_timing.bit_cnt), 64'd0);
        checkOutput("t6_lrclk_zero", {63'h0, a_lrclk}, 64'h0);
        stim[0] = 64'h0F0F_0F0F_F0F0_F0F0;
        applyStimulus(1, 260, 0, 0);
        checkOutput("t6_restart_pulses", 64'(rise_cyc.size()), 64'd1);
        if (rise_cyc.size() == 1) begin
            checkOutput("t6_restart_cycle", 64'(rise_cyc[0]), 64'd256);
            checkOutput("t6_restart_data", rise_data[0], stim[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
